pipe_perf_monitor: RTL and testbench

Synthesizable performance monitor for the pipelined CPU. It counts elapsed cycles and up to NUM_EVT per-cycle pipeline events, such as stall, flush, load-use bubble and branch-taken, in saturating counters. It stops by itself after a programmable cycle limit. It sits beside the CPU top-level; its event inputs are driven from the hazard detection unit and branch-resolve logic, and its readout goes to a debug/CSR port.

---
 rtl/perf_pkg.sv | 14 +
 rtl/perf_sat_counter.sv | 45 ++++
 rtl/pipe_perf_monitor.sv | 156 +++++++++++++++
 tb/tb_pipe_perf_monitor.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// Shared types and default widths for the pipeline performance monitor.
package perf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } perf_state_t;

    localparam int PERF_CNT_W   = 32;
    localparam int PERF_LIM_W   = 32;
    localparam int PERF_MAX_EVT = 16;

endpackage

// File: rtl/perf_sat_counter.sv
// Saturating up-counter with a sticky overflow flag.
// The flag is set when an increment arrives while the counter is already all-ones.
module perf_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o,
    output logic         ovf_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         ovf_q, ovf_d;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (inc_i) begin
            if (cnt_q == {W{1'b1}}) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/pipe_perf_monitor.sv
// Cycle and pipeline-event performance monitor with a self-stopping cycle limit.
// Define PERF_SNAPSHOT_EN to add a shadow bank that freezes all counters on snap_i.
module pipe_perf_monitor
    import perf_pkg::*;
#(
    parameter int NUM_EVT = 4,
    parameter int CNT_W   = PERF_CNT_W,
    parameter int LIM_W   = PERF_LIM_W
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  logic                                          start_i,
    input  logic                                          clr_i,
    input  logic [NUM_EVT-1:0]                            evt_i,
    input  logic [LIM_W-1:0]                              limit_i,
    input  logic [((NUM_EVT > 1) ? $clog2(NUM_EVT) : 1)-1:0] sel_i,
    input  logic                                          snap_i,
    output logic [CNT_W-1:0]                              cnt_o,
    output logic [CNT_W-1:0]                              cycle_o,
    output logic [NUM_EVT:0]                              ovf_o,
    output logic                                          run_o,
    output logic                                          done_o
);

    localparam int NC    = NUM_EVT + 1;
    localparam int SEL_W = (NUM_EVT > 1) ? $clog2(NUM_EVT) : 1;
    localparam int CMP_W = ((CNT_W > LIM_W) ? CNT_W : LIM_W) + 1;

    perf_state_t      state_q, state_d;
    logic             count_en;
    logic             limit_hit;
    logic [CMP_W-1:0] cyc_next;
    logic [NC-1:0]    inc;
    logic [NC-1:0]    ovf;
    logic [CNT_W-1:0] cnt  [NC];
    logic [CNT_W-1:0] post [NC];
    logic [CNT_W-1:0] rd   [NC];
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Slot NUM_EVT of every per-counter array is the cycle counter.
    always_comb begin
        count_en  = !clr_i && start_i && (state_q != DONE);
        cyc_next  = CMP_W'(cnt[NUM_EVT]) + CMP_W'(1);
        limit_hit = (limit_i != '0) && (cyc_next == CMP_W'(limit_i));
        for (int k = 0; k < NUM_EVT; k++) begin
            inc[k] = count_en && evt_i[k];
        end
        inc[NUM_EVT] = count_en;
        for (int k = 0; k < NC; k++) begin
            if (clr_i) begin
                post[k] = '0;
            end else if (inc[k] && (cnt[k] != {CNT_W{1'b1}})) begin
                post[k] = cnt[k] + CNT_W'(1);
            end else begin
                post[k] = cnt[k];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start_i) state_d = limit_hit ? DONE : RUN;
                RUN: begin
                    if (!start_i) begin
                        state_d = IDLE;
                    end else if (limit_hit) begin
                        state_d = DONE;
                    end
                end
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    for (genvar g = 0; g < NC; g++) begin : g_cnt
        perf_sat_counter #(.W(CNT_W)) u_cnt (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .inc_i (inc[g]),
            .clr_i (clr_i),
            .cnt_o (cnt[g]),
            .ovf_o (ovf[g])
        );
    end

`ifdef PERF_SNAPSHOT_EN
    logic [CNT_W-1:0] shadow_q [NC];
    logic [CNT_W-1:0] shadow_d [NC];
    logic             held_q, held_d;

    always_comb begin
        held_d   = held_q;
        shadow_d = shadow_q;
        if (clr_i) begin
            held_d = 1'b0;
            for (int k = 0; k < NC; k++) shadow_d[k] = '0;
        end else if (snap_i) begin
            held_d   = 1'b1;
            shadow_d = post;
        end
        rd = held_d ? shadow_d : post;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            held_q <= 1'b0;
            for (int k = 0; k < NC; k++) shadow_q[k] <= '0;
        end else begin
            held_q   <= held_d;
            shadow_q <= shadow_d;
        end
    end

    assign cycle_o = held_q ? shadow_q[NUM_EVT] : cnt[NUM_EVT];
`else
    logic unused_snap;
    assign unused_snap = snap_i;
    assign rd          = post;
    assign cycle_o     = cnt[NUM_EVT];
`endif

    // Out-of-range selects read as zero.
    always_comb begin
        cnt_d = '0;
        for (int k = 0; k < NUM_EVT; k++) begin
            if (sel_i == SEL_W'(k)) cnt_d = rd[k];
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign ovf_o  = ovf;
    assign run_o  = (state_q == RUN);
    assign done_o = (state_q == DONE);

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Directed bench for pipe_perf_monitor: a default instance plus a narrow
// (CNT_W=4, NUM_EVT=3) instance sharing the same stimulus.
module tb_pipe_perf_monitor;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        clr;
    logic [3:0]  evt;
    logic [31:0] limit;
    logic [1:0]  sel;
    logic        snap;

    logic [31:0] cnt_o, cycle_o;
    logic [4:0]  ovf_o;
    logic        run_o, done_o;

    logic [3:0]  s_cnt_o, s_cycle_o;
    logic [3:0]  s_ovf_o;
    logic        s_run_o, s_done_o;

    int n_checks = 0;
    int n_errors = 0;

    pipe_perf_monitor u_dut (
        .clk_i   (clk),
        .rst_i   (rst_n),
        .start_i (start),
        .clr_i   (clr),
        .evt_i   (evt),
        .limit_i (limit),
        .sel_i   (sel),
        .snap_i  (snap),
        .cnt_o   (cnt_o),
        .cycle_o (cycle_o),
        .ovf_o   (ovf_o),
        .run_o   (run_o),
        .done_o  (done_o)
    );

    pipe_perf_monitor #(.NUM_EVT(3), .CNT_W(4), .LIM_W(32)) u_small (
        .clk_i   (clk),
        .rst_i   (rst_n),
        .start_i (start),
        .clr_i   (clr),
        .evt_i   (evt[2:0]),
        .limit_i (limit),
        .sel_i   (sel),
        .snap_i  (snap),
        .cnt_o   (s_cnt_o),
        .cycle_o (s_cycle_o),
        .ovf_o   (s_ovf_o),
        .run_o   (s_run_o),
        .done_o  (s_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b1;
        clr   = 1'b0;
        evt   = 4'hf;
        limit = 32'd0;
        sel   = 2'd0;
        snap  = 1'b0;
        step();
        step();
        check("rst_cnt",   cnt_o,   0);
        check("rst_cycle", cycle_o, 0);
        check("rst_ovf",   ovf_o,   0);
        check("rst_run",   run_o,   0);
        check("rst_done",  done_o,  0);

        // Limit of 64, channel 0 pulsed every third cycle.
        start = 1'b0;
        evt   = 4'h0;
        #2 rst_n = 1'b1;
        limit = 32'd64;
        start = 1'b1;
        for (int i = 0; i < 64; i++) begin
            evt = (i % 3 == 0) ? 4'h1 : 4'h0;
            step();
            if (i == 62) begin
                check("lim_cycle63", cycle_o, 63);
                check("lim_done63",  done_o,  0);
                check("lim_run63",   run_o,   1);
            end
        end
        check("lim_done",  done_o,  1);
        check("lim_run",   run_o,   0);
        check("lim_cycle", cycle_o, 64);
        check("lim_cnt0",  cnt_o,   22);
        evt = 4'hf;
        repeat (5) step();
        check("done_cnt0",  cnt_o,   22);
        check("done_cycle", cycle_o, 64);
        check("done_hold",  done_o,  1);

        // Start gap: counts hold while start is low.
        evt   = 4'h0;
        start = 1'b0;
        clear_all();
        check("clr_done",  done_o,  0);
        check("clr_cycle", cycle_o, 0);
        limit = 32'd0;
        sel   = 2'd1;
        evt   = 4'h2;
        start = 1'b1;
        repeat (10) step();
        check("gap_run_hi", run_o, 1);
        start = 1'b0;
        step();
        check("gap_run_lo", run_o,   0);
        check("gap_cycle",  cycle_o, 10);
        repeat (4) step();
        start = 1'b1;
        repeat (10) step();
        check("gap_cycle20", cycle_o, 20);
        check("gap_cnt1",    cnt_o,   20);

        // Saturation on the narrow instance.
        start = 1'b0;
        evt   = 4'h0;
        clear_all();
        sel   = 2'd2;
        evt   = 4'h4;
        start = 1'b1;
        repeat (20) step();
        check("sat_cnt2",    s_cnt_o,   15);
        check("sat_cycle",   s_cycle_o, 15);
        check("sat_ovf",     s_ovf_o,   4'b1100);
        check("wide_cnt2",   cnt_o,     20);
        check("wide_cycle",  cycle_o,   20);
        check("wide_ovf",    ovf_o,     0);
        start = 1'b0;
        evt   = 4'h0;
        sel   = 2'd3;
        step();
        check("sel_oor", s_cnt_o, 0);

        // clr wins over start and events in the same cycle.
        sel   = 2'd0;
        evt   = 4'hf;
        start = 1'b1;
        repeat (3) step();
        check("pre_clr_cnt0", cnt_o, 3);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_cycle0", cycle_o,   0);
        check("clr_ovf",    ovf_o,     0);
        check("clr_sovf",   s_ovf_o,   0);
        check("clr_run",    run_o,     0);
        check("clr_cnt",    cnt_o,     0);
        start = 1'b0;
        evt   = 4'h0;
        step();
        check("clr_idle_cycle", cycle_o, 0);

        // Snapshot: counter 0 reaches 7, snap, then five more events.
        evt   = 4'h1;
        start = 1'b1;
        repeat (6) step();
        snap = 1'b1;
        step();
        snap = 1'b0;
        repeat (5) step();
`ifdef PERF_SNAPSHOT_EN
        check("snap_cnt0",  cnt_o,   7);
        check("snap_cycle", cycle_o, 7);
`else
        check("snap_cnt0",  cnt_o,   12);
        check("snap_cycle", cycle_o, 12);
`endif
        start = 1'b0;
        evt   = 4'h0;
        clear_all();
        check("snap_clr_cnt",   cnt_o,   0);
        check("snap_clr_cycle", cycle_o, 0);

        // Asynchronous reset between edges while running.
        evt   = 4'hf;
        start = 1'b1;
        repeat (3) step();
        check("pre_rst_cycle", cycle_o, 3);
        #3 rst_n = 1'b0;
        #1;
        check("arst_cnt",   cnt_o,   0);
        check("arst_cycle", cycle_o, 0);
        check("arst_ovf",   ovf_o,   0);
        check("arst_run",   run_o,   0);
        check("arst_done",  done_o,  0);
        start = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (2) step();
        check("post_rst_cycle", cycle_o, 0);
        check("post_rst_run",   run_o,   0);
        start = 1'b1;
        step();
        check("restart_cycle", cycle_o, 1);
        check("restart_run",   run_o,   1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
